// File: rtl/l2_port_arbiter_pkg.sv
// cacheLinePackage: MESI line state, L2 request kinds and L2 port arbiter FSM states
package cacheLinePackage;
  typedef enum logic [1:0] {INVALID = 2'd0, SHARED = 2'd1, EXCLUSIVE = 2'd2, MODIFIED = 2'd3} CacheState;
  typedef enum logic [1:0] {FETCH_RD = 2'd0, FETCH_WR = 2'd1, EVICT = 2'd2} l2_req_kind_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESPOND = 2'd3} l2_arb_state_t;
endpackage

// File: rtl/l2_port_arbiter_rr_priority_select.sv
// rr_priority_select: combinational round-robin picker, first set request at or after ptr with wrap
module rr_priority_select #(
  parameter int N = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_valid
);
  logic [N-1:0] rot;
  assign rot = N'({req, req} >> ptr);
  always_comb begin
    grant = '0;
    any_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) begin
        grant = IW'((int'(ptr) + i) % N);
        any_valid = 1'b1;
      end
  end
endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin share of the single L2 request port among NUM_REQ L1 controllers
module l2_port_arbiter
  import cacheLinePackage::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  l2_req_kind_t [NUM_REQ-1:0] req_kind,
  input  logic [NUM_REQ-1:0][31:0]  req_addr,
  input  logic [NUM_REQ-1:0][127:0] req_wdata,
  input  CacheState [NUM_REQ-1:0]   req_mesi,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_hit,
  output logic                      resp_err,
  output logic [127:0]              resp_data,
  output logic                      l2_read,
  output logic                      l2_write,
  output logic                      l2_read_from_L2,
  output logic                      l2_write_to_L2,
  output logic [31:0]               l2_addr,
  output logic [127:0]              l2_data_in,
  output CacheState                 l2_newMESI,
  input  logic [127:0]              l2_data_out,
  input  logic                      l2_hit,
  input  logic                      l2_done,
  output logic                      busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  l2_arb_state_t state;
  logic [IW-1:0] rr_ptr, gnt, pick;
  logic any;
  l2_req_kind_t h_kind;
  logic [31:0] h_addr;
  logic [127:0] h_wdata, r_data;
  CacheState h_mesi;
  logic [CW-1:0] cnt;
  logic r_hit, r_err, drive_l2;
  rr_priority_select #(.N(NUM_REQ), .IW(IW)) u_sel (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(pick),
    .any_valid(any)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      gnt <= '0;
      cnt <= '0;
      h_kind <= FETCH_RD;
      h_addr <= '0;
      h_wdata <= '0;
      h_mesi <= INVALID;
      r_hit <= 1'b0;
      r_err <= 1'b0;
      r_data <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state <= ISSUE;
          gnt <= pick;
          rr_ptr <= (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
          h_kind <= req_kind[pick];
          h_addr <= req_addr[pick];
          h_wdata <= req_wdata[pick];
          h_mesi <= req_mesi[pick];
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT;
        end
        // l2_done takes priority over a timeout landing in the same cycle
        WAIT: if (l2_done) begin
          state <= RESPOND;
          r_hit <= l2_hit && h_kind != EVICT;
          r_data <= (h_kind == EVICT) ? '0 : l2_data_out;
          r_err <= 1'b0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state <= RESPOND;
          r_hit <= 1'b0;
          r_data <= '0;
          r_err <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
  assign drive_l2 = state == ISSUE || state == WAIT;
  assign req_ready = (state == IDLE && any && !reset) ? NUM_REQ'(1) << pick : '0;
  assign resp_valid = (state == RESPOND) ? NUM_REQ'(1) << gnt : '0;
  assign resp_hit = state == RESPOND && r_hit;
  assign resp_err = state == RESPOND && r_err;
  assign resp_data = (state == RESPOND) ? r_data : '0;
  assign l2_read = state == ISSUE && h_kind == FETCH_RD;
  assign l2_write = state == ISSUE && h_kind == FETCH_WR;
  assign l2_read_from_L2 = state == ISSUE && h_kind != EVICT;
  assign l2_write_to_L2 = state == ISSUE && h_kind == EVICT;
  assign l2_addr = drive_l2 ? h_addr : '0;
  assign l2_data_in = drive_l2 ? h_wdata : '0;
  assign l2_newMESI = drive_l2 ? h_mesi : INVALID;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed vector table, corner sequences and random traffic against a transaction-timeline model
module tb_l2_port_arbiter;
  import cacheLinePackage::*;
  localparam int N = 3;
  localparam int TO = 8;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  l2_req_kind_t [N-1:0] req_kind;
  logic [N-1:0][31:0] req_addr;
  logic [N-1:0][127:0] req_wdata;
  CacheState [N-1:0] req_mesi;
  logic [N-1:0] req_ready, resp_valid;
  logic resp_hit, resp_err, l2_read, l2_write, l2_read_from_L2, l2_write_to_L2, busy;
  logic [127:0] resp_data, l2_data_in, l2_data_out;
  logic [31:0] l2_addr;
  CacheState l2_newMESI;
  logic l2_hit, l2_done;

  l2_port_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_kind(req_kind), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mesi(req_mesi), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .resp_err(resp_err), .resp_data(resp_data), .l2_read(l2_read),
    .l2_write(l2_write), .l2_read_from_L2(l2_read_from_L2), .l2_write_to_L2(l2_write_to_L2),
    .l2_addr(l2_addr), .l2_data_in(l2_data_in), .l2_newMESI(l2_newMESI), .l2_data_out(l2_data_out),
    .l2_hit(l2_hit), .l2_done(l2_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] v;
    logic done;
    logic hit;
    logic [N-1:0] rr;
    logic rd;
    logic [N-1:0] rv;
    logic rhit;
    logic bsy;
  } vec_t;
  vec_t tbl [6];

  int checks = 0, passes = 0;
  // model: m_age counts cycles since the grant (0 = no transaction), m_end is the respond age once known
  int m_age = 0, m_end = 0, m_owner = 0, m_ptr = 0, m_w = -1;
  l2_req_kind_t m_kind = FETCH_RD;
  logic [31:0] m_addr = '0;
  logic [127:0] m_wdata = '0, m_data = '0;
  CacheState m_mesi = INVALID;
  logic m_hit = 1'b0, m_err = 1'b0;
  logic [N-1:0] pend = '0;
  bit rnd_req = 1'b0;
  int mode = 0, dly = 0, first, ng, nw;
  logic [127:0] dpat = 128'hDEADBEEF_00000000_00000000_00000001;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passes++;
  endtask

  task automatic check_model();
    logic [N-1:0] e_rr, e_rv, sh;
    logic iss, wt, rsp, ev;
    m_w = -1;
    if (m_age == 0 && !reset)
      for (int k = N - 1; k >= 0; k--) begin
        sh = req_valid >> ((m_ptr + k) % N);
        if (sh[0]) m_w = (m_ptr + k) % N;
      end
    iss = m_age == 1;
    rsp = m_age > 0 && m_age == m_end;
    wt = m_age >= 2 && !rsp;
    ev = m_kind == EVICT;
    e_rr = (m_w >= 0) ? N'(1) << m_w : '0;
    e_rv = rsp ? N'(1) << m_owner : '0;
    chk("req_ready", 128'(req_ready), 128'(e_rr));
    chk("resp_valid", 128'(resp_valid), 128'(e_rv));
    chk("resp_hit", 128'(resp_hit), 128'(rsp && !ev && m_hit));
    chk("resp_err", 128'(resp_err), 128'(rsp && m_err));
    chk("resp_data", resp_data, (rsp && !ev) ? m_data : '0);
    chk("l2_read", 128'(l2_read), 128'(iss && m_kind == FETCH_RD));
    chk("l2_write", 128'(l2_write), 128'(iss && m_kind == FETCH_WR));
    chk("l2_read_from_L2", 128'(l2_read_from_L2), 128'(iss && !ev));
    chk("l2_write_to_L2", 128'(l2_write_to_L2), 128'(iss && ev));
    chk("l2_addr", 128'(l2_addr), 128'((iss || wt) ? m_addr : 32'h0));
    chk("l2_data_in", l2_data_in, (iss || wt) ? m_wdata : '0);
    chk("l2_newMESI", 128'(l2_newMESI), 128'((iss || wt) ? m_mesi : INVALID));
    chk("busy", 128'(busy), 128'(m_age > 0));
  endtask

  task automatic update_model();
    if (reset) begin
      m_age = 0;
      m_end = 0;
      m_ptr = 0;
    end else if (m_age == 0) begin
      if (m_w >= 0) begin
        m_age = 1;
        m_end = 0;
        m_owner = m_w;
        m_kind = req_kind[IW'(m_w)];
        m_addr = req_addr[IW'(m_w)];
        m_wdata = req_wdata[IW'(m_w)];
        m_mesi = req_mesi[IW'(m_w)];
        m_ptr = (m_w + 1) % N;
        pend[IW'(m_w)] = 1'b0;
      end
    end else if (m_age == m_end) m_age = 0;
    else begin
      if (m_age >= 2 && m_end == 0) begin
        if (l2_done) begin
          m_end = m_age + 1;
          m_hit = l2_hit;
          m_data = l2_data_out;
          m_err = 1'b0;
        end else if (m_age - 2 == TO - 1) begin
          m_end = m_age + 1;
          m_hit = 1'b0;
          m_data = '0;
          m_err = 1'b1;
        end
      end
      m_age++;
    end
  endtask

  task automatic tick();
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic pre();
    if (rnd_req)
      for (int i = 0; i < N; i++)
        if (!pend[IW'(i)] && $urandom_range(0, 2) == 0) begin
          pend[IW'(i)] = 1'b1;
          req_kind[IW'(i)] = l2_req_kind_t'($urandom_range(0, 2));
          req_addr[IW'(i)] = $urandom;
          req_wdata[IW'(i)] = {$urandom, $urandom, $urandom, $urandom};
          req_mesi[IW'(i)] = CacheState'($urandom_range(0, 3));
        end
    req_valid = pend;
    l2_done = mode == 3 || (mode == 1 && m_age == 2 + dly) || (mode == 2 && $urandom_range(0, 3) == 0);
    l2_hit = (mode == 2) ? 1'($urandom) : 1'b1;
    l2_data_out = (mode == 2) ? {$urandom, $urandom, $urandom, $urandom} : dpat;
    #3;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend = '0;
    mode = 0;
    rnd_req = 1'b0;
    pre();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tbl = '{
      '{3'b001, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0},
      '{3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1},
      '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1},
      '{3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1},
      '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b001, 1'b1, 1'b1},
      '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0}};
    for (int i = 0; i < N; i++) begin
      req_kind[IW'(i)] = FETCH_RD;
      req_addr[IW'(i)] = '0;
      req_wdata[IW'(i)] = '0;
      req_mesi[IW'(i)] = INVALID;
    end
    l2_done = 1'b0;
    l2_hit = 1'b0;
    l2_data_out = '0;
    @(posedge clk);
    #1;
    // single FETCH_RD from req0, vectors applied directly
    do_reset();
    req_addr[0] = 32'h0000_0040;
    for (int c = 0; c < 6; c++) begin
      req_valid = tbl[c].v;
      l2_done = tbl[c].done;
      l2_hit = tbl[c].hit;
      l2_data_out = dpat;
      #3;
      chk($sformatf("t1[%0d] req_ready", c), 128'(req_ready), 128'(tbl[c].rr));
      chk($sformatf("t1[%0d] rd strobe", c), 128'(l2_read_from_L2 && l2_read), 128'(tbl[c].rd));
      chk($sformatf("t1[%0d] resp_valid", c), 128'(resp_valid), 128'(tbl[c].rv));
      chk($sformatf("t1[%0d] resp_hit", c), 128'(resp_hit), 128'(tbl[c].rhit));
      chk($sformatf("t1[%0d] resp_data", c), resp_data, tbl[c].rv[0] ? dpat : '0);
      chk($sformatf("t1[%0d] busy", c), 128'(busy), 128'(tbl[c].bsy));
      tick();
    end
    // req0 and req1 continuously valid, L2 answers in the first WAIT cycle
    do_reset();
    mode = 1;
    dly = 0;
    req_kind[1] = FETCH_WR;
    ng = 0;
    for (int c = 0; c < 16; c++) begin
      pend[0] = 1'b1;
      pend[1] = 1'b1;
      pre();
      if (req_ready != 0) begin
        chk("t2 grant idx", 128'($clog2(int'(req_ready))), 128'(ng % 2));
        chk("t2 grant cycle", 128'(c), 128'(4 * ng));
        ng++;
      end
      tick();
    end
    chk("t2 grant count", 128'(ng), 128'(4));
    // EVICT from req1
    do_reset();
    mode = 1;
    dly = 3;
    req_kind[1] = EVICT;
    req_addr[1] = 32'h0000_0100;
    req_mesi[1] = MODIFIED;
    req_wdata[1] = {16{8'hA5}};
    pend[1] = 1'b1;
    nw = 0;
    for (int c = 0; c < 8; c++) begin
      pre();
      nw += int'(l2_write_to_L2);
      if (c == 1) begin
        chk("t3 write_to_L2", 128'(l2_write_to_L2), 128'(1));
        chk("t3 newMESI", 128'(l2_newMESI), 128'(MODIFIED));
        chk("t3 data_in", l2_data_in, {16{8'hA5}});
      end
      if (c >= 2 && c <= 5) chk("t3 addr hold", 128'(l2_addr), 128'(32'h100));
      if (c == 6) begin
        chk("t3 resp_valid", 128'(resp_valid), 128'(3'b010));
        chk("t3 resp_hit", 128'(resp_hit), 128'(0));
        chk("t3 resp_data", resp_data, '0);
      end
      tick();
    end
    chk("t3 write strobes", 128'(nw), 128'(1));
    // FETCH_WR with no l2_done times out, then req2 is served normally
    do_reset();
    req_kind[0] = FETCH_WR;
    req_addr[0] = 32'h0000_2000;
    pend[0] = 1'b1;
    first = -1;
    for (int c = 0; c < 14; c++) begin
      pre();
      if (resp_valid != 0 && first < 0) begin
        first = c;
        chk("t4 resp_valid", 128'(resp_valid), 128'(3'b001));
        chk("t4 err", 128'(resp_err), 128'(1));
        chk("t4 hit", 128'(resp_hit), 128'(0));
        chk("t4 data", resp_data, '0);
      end
      tick();
    end
    chk("t4 timeout cycle", 128'(first), 128'(2 + TO));
    mode = 1;
    dly = 0;
    req_kind[2] = FETCH_RD;
    pend[2] = 1'b1;
    first = -1;
    for (int c = 0; c < 8; c++) begin
      pre();
      if (resp_valid != 0 && first < 0) begin
        first = c;
        chk("t4b resp_valid", 128'(resp_valid), 128'(3'b100));
        chk("t4b err", 128'(resp_err), 128'(0));
        chk("t4b data", resp_data, dpat);
      end
      tick();
    end
    chk("t4b resp cycle", 128'(first), 128'(3));
    // reset in WAIT, then req1 and req2 together: rr_ptr back at 0 gives req1
    do_reset();
    req_kind[1] = FETCH_RD;
    pend[1] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      reset = c == 3;
      mode = (c >= 4) ? 1 : 0;
      if (c == 4) begin
        pend[1] = 1'b1;
        pend[2] = 1'b1;
      end
      pre();
      if (c == 4) begin
        chk("t5 busy", 128'(busy), 128'(0));
        chk("t5 resp_valid", 128'(resp_valid), 128'(0));
        chk("t5 l2_addr", 128'(l2_addr), 128'(0));
        chk("t5 newMESI", 128'(l2_newMESI), 128'(INVALID));
        chk("t5 req_ready", 128'(req_ready), 128'(3'b010));
      end
      if (c == 7) chk("t5 resp after reset", 128'(resp_valid), 128'(3'b010));
      tick();
    end
    reset = 1'b0;
    // stray l2_done in IDLE, then l2_done on the timeout cycle
    do_reset();
    mode = 3;
    for (int c = 0; c < 3; c++) begin
      pre();
      chk("t6 stray busy", 128'(busy), 128'(0));
      chk("t6 stray resp", 128'(resp_valid), 128'(0));
      tick();
    end
    mode = 1;
    dly = TO - 1;
    req_kind[0] = FETCH_RD;
    pend[0] = 1'b1;
    first = -1;
    for (int c = 0; c < 14; c++) begin
      pre();
      if (resp_valid != 0 && first < 0) begin
        first = c;
        chk("t6 err", 128'(resp_err), 128'(0));
        chk("t6 hit", 128'(resp_hit), 128'(1));
        chk("t6 data", resp_data, dpat);
      end
      tick();
    end
    chk("t6 resp cycle", 128'(first), 128'(2 + TO));
    // random traffic with occasional resets
    do_reset();
    rnd_req = 1'b1;
    mode = 2;
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(0, 499) == 0;
      pre();
      tick();
    end
    reset = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
